priority_encoder_83: RTL and testbench
======================================

PRIORITY_ENCODER_83 -- requirements
Module: priority_encoder_83

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 8 request channels and a 3-bit code.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 E  input  1  enable; high = capture requests and issue codes.
REQ-005 I0n..I7n  input  1 each  active-low request lines; I7n highest priority, I0n lowest.
REQ-006 ready  input  1  consumer accepts the current code when high with valid.
REQ-007 A0, A1, A2  output  1 each  registered code {A2,A1,A0} of the granted channel.
REQ-008 valid  output  1  registered; code on A2..A0 is valid.
REQ-009 GSn  output  1  group-select, active-low; equals ~valid.
REQ-010 EOn  output  1  enable-out, active-low; low only when E=1, no pending bit set and valid=0.
REQ-011 ovf  output  1  registered one-cycle pulse; a request edge hit an already-pending channel.

Function
REQ-012 The block SHALL register I0n..I7n each cycle into prev[7:0]; a request edge on channel k = prev[k]=1 and current Ik_n=0, sampled at a rising edge.
REQ-013 While E=1, a request edge on channel k SHALL set pending[k] at that edge; while E=0, edges SHALL be ignored (prev still updates).
REQ-014 A held-low line SHALL produce exactly one request; a new request needs the line to return high for at least one sampled cycle.
REQ-015 When valid=0, E=1 and pending!=0, the block SHALL load the highest-index pending channel into {A2,A1,A0} and set valid at the next edge.
REQ-016 Latency: line sampled low at edge N (high at N-1), block idle -> pending set at N, valid=1 with code after edge N+1.
REQ-017 valid, A2..A0 SHALL hold stable until valid&&ready at a rising edge (accept).
REQ-018 On accept, pending[code] SHALL clear; if the remaining pending bits (excluding the accepted bit and same-edge new sets) are nonzero and E=1, the next highest code SHALL load at the same edge and valid SHALL stay 1 (back-to-back, one code per cycle); otherwise valid SHALL fall.
REQ-019 Simultaneous clear and new edge on the same channel SHALL leave pending[k]=1 (set wins); no ovf in that case.
REQ-020 A request edge on channel k while pending[k]=1 and no same-edge clear SHALL assert ovf for exactly one cycle; the request merges.
REQ-021 E=0 SHALL NOT drop a code already valid; it SHALL block loading of new codes; pending bits SHALL be retained.
REQ-022 A higher-priority request arriving while a lower code is valid SHALL NOT replace it; it is served at the next load.
REQ-023 ready while valid=0 SHALL have no effect.

Reset
REQ-024 rst_n=0 SHALL asynchronously force pending=0, prev=8'hFF, valid=0, A2..A0=0, ovf=0; thus GSn=1, EOn=~E.
REQ-025 Lines held low across reset deassertion SHALL NOT generate a request (prev=FF; the first sampled low after reset counts as an edge only if preceded by a high sample).
REQ-026 Reset asserted mid-transfer SHALL discard the valid code and all pending bits; no code issues after release without a new edge.

Verification
REQ-027 Reset, E=1, pulse I5n low 1 cycle, ready=1 -> valid=1 with {A2,A1,A0}=101 two edges after the sampled low, valid=0 one cycle later, EOn returns 0.
REQ-028 Same-edge pulses on I2n, I6n, I7n, ready=0 for 3 cycles then 1 -> code 111 held 3 cycles, then 110, 010 on consecutive cycles, valid falls after 010.
REQ-029 I3n held low for 10 cycles, ready=1 -> exactly one code 011 issued; ovf never asserts.
REQ-030 I4n pulsed twice while code 111 held (ready=0) -> ovf pulses once on second edge; 100 issued once after 111 accepted.
REQ-031 E=0, pulse I1n -> no pending, valid stays 0, EOn=1; E=1 then -> still no code; with code 000 valid and E dropped -> code holds until accepted.
REQ-032 Reset asserted while valid=1 with two pending -> valid=0, GSn=1 immediately; after release with inputs high, no code issues.

Source files
------------

// File: rtl/priority_encoder_83_if.sv
// Request/grant bundle for the 8-to-3 priority encoder.
// The master side (producer of requests, consumer of codes) drives the
// enable, the active-low request lines and ready. The slave side (the
// encoder) returns the code, the handshake and the status flags.
interface priority_encoder_83_if;
    logic E;
    logic I0n;
    logic I1n;
    logic I2n;
    logic I3n;
    logic I4n;
    logic I5n;
    logic I6n;
    logic I7n;
    logic ready;
    logic A0;
    logic A1;
    logic A2;
    logic valid;
    logic GSn;
    logic EOn;
    logic ovf;

    modport master (
        output E, I0n, I1n, I2n, I3n, I4n, I5n, I6n, I7n, ready,
        input  A0, A1, A2, valid, GSn, EOn, ovf
    );

    modport slave (
        input  E, I0n, I1n, I2n, I3n, I4n, I5n, I6n, I7n, ready,
        output A0, A1, A2, valid, GSn, EOn, ovf
    );
endinterface

// File: rtl/priority_encoder_83.sv
// Edge-triggered 8-to-3 priority encoder with a valid/ready output.
// Falling edges on the active-low request lines latch into a pending set;
// the highest pending channel is issued as a registered 3-bit code and held
// until accepted, after which the next code (if any) follows on the same edge.
module priority_encoder_83 (
    input  logic                  clk,
    input  logic                  rst_n,
    priority_encoder_83_if.slave  bus
);

    logic [7:0] req_lines;
    logic [7:0] prev;
    logic [7:0] pending;
    logic [7:0] edges;
    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    logic [7:0] remaining;
    logic [2:0] code;
    logic       code_valid;
    logic       ovf_pulse;
    logic       primed;
    logic       accept;
    logic       load;

    // Index of the highest set bit; zero when nothing is set.
    function automatic logic [2:0] highest(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    assign req_lines = {bus.I7n, bus.I6n, bus.I5n, bus.I4n,
                        bus.I3n, bus.I2n, bus.I1n, bus.I0n};

    // A request is a high-to-low transition between two real samples. The
    // primed flag keeps the reset value of prev from turning a line that was
    // already low at reset release into a request.
    assign edges     = primed ? (prev & ~req_lines) : 8'h00;
    assign set_bits  = bus.E ? edges : 8'h00;
    assign accept    = code_valid && bus.ready;
    assign clr_bits  = accept ? (8'b1 << code) : 8'h00;
    // Pending channels still waiting after this edge's accept; same-edge new
    // requests are deliberately excluded so a fresh request waits one cycle.
    assign remaining = pending & ~clr_bits;
    assign load      = (!code_valid || accept) && bus.E && (remaining != 8'h00);

    // Request capture, pending bookkeeping and code issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= 8'hFF;
            primed     <= 1'b0;
            pending    <= 8'h00;
            code       <= 3'd0;
            code_valid <= 1'b0;
            ovf_pulse  <= 1'b0;
        end else begin
            prev      <= req_lines;
            primed    <= 1'b1;
            // Set wins over a same-edge clear on the same channel.
            pending   <= remaining | set_bits;
            // A new request on a channel that stays pending merges and flags ovf.
            ovf_pulse <= |(set_bits & remaining);
            if (load) begin
                code       <= highest(remaining);
                code_valid <= 1'b1;
            end else if (accept) begin
                code_valid <= 1'b0;
            end
        end
    end

    assign bus.A0    = code[0];
    assign bus.A1    = code[1];
    assign bus.A2    = code[2];
    assign bus.valid = code_valid;
    assign bus.GSn   = ~code_valid;
    assign bus.EOn   = ~(bus.E && (pending == 8'h00) && !code_valid);
    assign bus.ovf   = ovf_pulse;

endmodule

// File: tb/tb_priority_encoder_83.sv
// Directed bench for priority_encoder_83: hand-computed codes, handshake
// timing, ovf pulses, enable gating and reset behaviour.
module tb_priority_encoder_83;

    logic clk;
    logic rst_n;
    int   checks_total;
    int   checks_passed;
    int   issued;
    int   ovf_seen;

    priority_encoder_83_if bus ();

    priority_encoder_83 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp)
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        else
            checks_passed++;
    endtask

    // Drive the eight active-low request lines (bit k -> IkN).
    task automatic set_lines(input logic [7:0] v);
        bus.I0n = v[0]; bus.I1n = v[1]; bus.I2n = v[2]; bus.I3n = v[3];
        bus.I4n = v[4]; bus.I5n = v[5]; bus.I6n = v[6]; bus.I7n = v[7];
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] code_out();
        return {bus.A2, bus.A1, bus.A0};
    endfunction

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n     = 1'b0;
        bus.E     = 1'b1;
        bus.ready = 1'b0;
        // I6n held low across reset release must not produce a request.
        set_lines(8'hBF);
        #12;
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_gsn", bus.GSn, 1'b1);
        chk("rst_eon_e1", bus.EOn, 1'b0);
        chk("rst_code", code_out(), 3'd0);
        chk("rst_ovf", bus.ovf, 1'b0);
        bus.E = 1'b0;
        #1;
        chk("rst_eon_e0", bus.EOn, 1'b1);
        bus.E = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick(); tick(); tick();
        chk("held_low_no_req", bus.valid, 1'b0);
        chk("held_low_eon", bus.EOn, 1'b0);
        set_lines(8'hFF);
        tick(); tick();

        // Single pulse on I5n with ready high.
        bus.ready = 1'b1;
        set_lines(8'hDF);
        tick();
        chk("p5_not_yet_valid", bus.valid, 1'b0);
        chk("p5_pending_eon", bus.EOn, 1'b1);
        set_lines(8'hFF);
        tick();
        chk("p5_valid", bus.valid, 1'b1);
        chk("p5_code", code_out(), 3'd5);
        chk("p5_gsn", bus.GSn, 1'b0);
        tick();
        chk("p5_valid_fall", bus.valid, 1'b0);
        chk("p5_eon_back", bus.EOn, 1'b0);

        // Same-edge pulses on I2n, I6n, I7n; ready low for three cycles.
        bus.ready = 1'b0;
        set_lines(8'h3B);
        tick();
        set_lines(8'hFF);
        tick();
        chk("multi_hold1", code_out(), 3'd7);
        chk("multi_valid1", bus.valid, 1'b1);
        tick();
        chk("multi_hold2", code_out(), 3'd7);
        tick();
        chk("multi_hold3", code_out(), 3'd7);
        bus.ready = 1'b1;
        tick();
        chk("multi_code6", code_out(), 3'd6);
        chk("multi_valid6", bus.valid, 1'b1);
        tick();
        chk("multi_code2", code_out(), 3'd2);
        chk("multi_valid2", bus.valid, 1'b1);
        tick();
        chk("multi_valid_fall", bus.valid, 1'b0);

        // I3n held low for ten cycles: one request only.
        issued   = 0;
        ovf_seen = 0;
        set_lines(8'hF7);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.valid && bus.ready && code_out() == 3'd3) issued++;
            if (bus.ovf) ovf_seen++;
        end
        set_lines(8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.valid) issued++;
            if (bus.ovf) ovf_seen++;
        end
        chk("hold3_issued_once", issued, 1);
        chk("hold3_no_ovf", ovf_seen, 0);

        // Two I4n pulses while code 7 is held.
        bus.ready = 1'b0;
        set_lines(8'h7F);
        tick();
        set_lines(8'hFF);
        tick();
        chk("ovf_hold7", code_out(), 3'd7);
        set_lines(8'hEF);
        tick();
        chk("ovf_first_edge", bus.ovf, 1'b0);
        set_lines(8'hFF);
        tick();
        chk("ovf_gap", bus.ovf, 1'b0);
        set_lines(8'hEF);
        tick();
        chk("ovf_second_edge", bus.ovf, 1'b1);
        set_lines(8'hFF);
        tick();
        chk("ovf_one_cycle", bus.ovf, 1'b0);
        chk("ovf_code_still7", code_out(), 3'd7);
        bus.ready = 1'b1;
        tick();
        chk("ovf_code4", code_out(), 3'd4);
        chk("ovf_valid4", bus.valid, 1'b1);
        tick();
        chk("ovf_4_once", bus.valid, 1'b0);
        tick();
        chk("ovf_4_no_repeat", bus.valid, 1'b0);

        // Enable low ignores requests.
        bus.ready = 1'b0;
        bus.E     = 1'b0;
        set_lines(8'hFD);
        tick();
        set_lines(8'hFF);
        tick();
        chk("e0_no_valid", bus.valid, 1'b0);
        chk("e0_eon", bus.EOn, 1'b1);
        bus.E = 1'b1;
        #1;
        chk("e1_no_pending_eon", bus.EOn, 1'b0);
        tick(); tick();
        chk("e1_still_no_code", bus.valid, 1'b0);
        // Code 0 valid, then enable dropped: code holds until accepted.
        set_lines(8'hFE);
        tick();
        set_lines(8'hFF);
        tick();
        chk("c0_valid", bus.valid, 1'b1);
        chk("c0_code", code_out(), 3'd0);
        bus.E = 1'b0;
        tick(); tick(); tick();
        chk("c0_hold_valid", bus.valid, 1'b1);
        chk("c0_hold_code", code_out(), 3'd0);
        bus.ready = 1'b1;
        tick();
        chk("c0_accepted", bus.valid, 1'b0);
        chk("c0_eon_e0", bus.EOn, 1'b1);
        bus.E = 1'b1;

        // Reset mid-transfer with two channels still pending.
        bus.ready = 1'b0;
        set_lines(8'hD5);
        tick();
        set_lines(8'hFF);
        tick();
        chk("mid_valid", bus.valid, 1'b1);
        chk("mid_code", code_out(), 3'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.valid, 1'b0);
        chk("mid_rst_gsn", bus.GSn, 1'b1);
        #2 rst_n = 1'b1;
        issued = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.valid) issued++;
        end
        chk("mid_no_code_after", issued, 0);
        chk("mid_eon_idle", bus.EOn, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
